alu_wb_stage: RTL
=================

// Module: alu_wb_stage
// PURPOSE
//  Execute->write-back stage directly downstream of the ALU. Captures ALU result and
//  flags into a valid/ready pipeline register, owns the architectural flag register (FR),
//  and resolves conditional branches against FR. Feeds register-file write port and PC unit.
// PARAMETERS
//  REG_ADDR_W  3   destination register index width (8 GPRs)
//  COND_W      4   branch condition code width
// PORTS
//  clk           in   1            system clock, all state on rising edge
//  rst           in   1            synchronous reset, active-high
//  ex_valid      in   1            upstream holds a valid ALU result
//  ex_ready      out  1            stage accepts this cycle
//  ex_y          in   `DATA_W      ALU result y
//  ex_flags      in   `FR_FLAG_W   ALU flags {N,Z,C,V} at `N_FLAG/`Z_FLAG/`C_FLAG/`V_FLAG
//  ex_flag_we    in   1            instruction updates FR
//  ex_rd         in   REG_ADDR_W   destination register
//  ex_rd_we      in   1            instruction writes rd
//  ex_is_br      in   1            instruction is a conditional branch
//  ex_cond       in   COND_W       branch condition code
//  ex_br_target  in   `DATA_W      branch target address
//  wb_valid      out  1            write-back entry valid
//  wb_ready      in   1            register file consumes entry
//  wb_data       out  `DATA_W      data to write
//  wb_rd         out  REG_ADDR_W   register index
//  wb_we         out  1            write enable (qualified: wb_valid & captured rd_we)
//  fr            out  `FR_FLAG_W   architectural flag register
//  br_taken      out  1            one-cycle pulse: branch taken
//  br_target     out  `DATA_W      target, valid while br_taken
// BEHAVIOUR
//  - accept = ex_valid & ex_ready; release = wb_valid & wb_ready.
//  - Reset: wb_valid=0, wb_data=0, wb_rd=0, wb_we=0, fr=0, br_taken=0, br_target=0.
//  - Latency: accepted result on wb_* the next cycle. wb_* hold stable while wb_valid&~wb_ready.
//  - wb_valid next = accept | (wb_valid & ~wb_ready); accept and release same cycle -> replace.
//  - FR: on accept with ex_flag_we, fr <= ex_flags next cycle; otherwise holds. FR ignores wb_ready.
//  - Branch: on accept with ex_is_br, evaluate cond on current fr (pre-update value, even if
//    ex_flag_we also set); br_taken=1 and br_target=ex_br_target next cycle, exactly one cycle.
//    br_taken=0 otherwise. Branches with ex_rd_we=0 still occupy a wb slot (wb_we=0).
//  - Cond codes: 0 AL,1 EQ Z,2 NE ~Z,3 CS C,4 CC ~C,5 MI N,6 PL ~N,7 VS V,8 VC ~V,
//    9 GE N==V,10 LT N!=V,11 GT ~Z&(N==V),12 LE Z|(N!=V),13 HI ~C&~Z,14 LS C|Z,15 NV.
//    C is borrow after SUB (C=1 means a<b unsigned), hence HI/LS polarity.
//  - Back-to-back flag set then branch: branch accepted the cycle after the setter sees new fr.
//  - Reset mid-operation: pending entry dropped, no write, no br_taken pulse emitted.
// CONFIGURATION
//  WB_SKID_EN defined: 2-entry skid buffer; ex_ready is a registered signal
//    (=1 whenever skid entry empty), no combinational path wb_ready->ex_ready; on stall
//    the in-flight accept lands in skid, drained in order before new input. Throughput 1/cycle.
//  WB_SKID_EN undefined: single entry; ex_ready = ~wb_valid | wb_ready (combinational).
//  FR/branch semantics identical in both; both give 1-cycle latency when not stalled.
// TESTING
//  - rst=1 two cycles mid-stall -> all outputs 0, ex_ready=1 after release.
//  - ex_y=16'h1234, rd=3, rd_we=1, wb_ready=1 -> next cycle wb_valid=1, wb_data=16'h1234, wb_rd=3, wb_we=1.
//  - wb_ready=0 3 cycles, upstream presents 2 results -> wb_* stable; no loss/duplication,
//    in-order delivery after wb_ready=1 (skid: both captured; no skid: ex_ready=0 stalls).
//  - flags Z=1 flag_we=1, then branch cond=1 EQ target 16'h0040 -> br_taken pulse 1 cycle, br_target=16'h0040.
//  - fr C=1, branch cond=13 HI -> br_taken=0; cond=14 LS -> br_taken=1.
//  - branch with flag_we=1 in same instruction, fr Z=0, ex_flags Z=1, cond EQ -> not taken, fr.Z=1 after.

Source files
------------

// File: rtl/alu_wb_stage_if.sv
// Bundle between the ALU execute stage, the write-back stage and the register file / PC unit.
// Data width and flag layout come from the DATA_W / FR_FLAG_W / *_FLAG macros (defaults below).
`ifndef DATA_W
  `define DATA_W 16
`endif
`ifndef FR_FLAG_W
  `define FR_FLAG_W 4
`endif
`ifndef N_FLAG
  `define N_FLAG 3
`endif
`ifndef Z_FLAG
  `define Z_FLAG 2
`endif
`ifndef C_FLAG
  `define C_FLAG 1
`endif
`ifndef V_FLAG
  `define V_FLAG 0
`endif

interface alu_wb_stage_if #(
  parameter int REG_ADDR_W = 3,
  parameter int COND_W     = 4
);
  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // A producer that raises valid holds it and its payload steady until that transfer.
  logic                    ex_valid;
  logic                    ex_ready;
  logic [`DATA_W-1:0]      ex_y;
  logic [`FR_FLAG_W-1:0]   ex_flags;
  logic                    ex_flag_we;
  logic [REG_ADDR_W-1:0]   ex_rd;
  logic                    ex_rd_we;
  logic                    ex_is_br;
  logic [COND_W-1:0]       ex_cond;
  logic [`DATA_W-1:0]      ex_br_target;

  logic                    wb_valid;
  logic                    wb_ready;
  logic [`DATA_W-1:0]      wb_data;
  logic [REG_ADDR_W-1:0]   wb_rd;
  logic                    wb_we;

  logic [`FR_FLAG_W-1:0]   fr;
  logic                    br_taken;
  logic [`DATA_W-1:0]      br_target;

  modport slave (
    input  ex_valid, ex_y, ex_flags, ex_flag_we, ex_rd, ex_rd_we, ex_is_br, ex_cond,
           ex_br_target, wb_ready,
    output ex_ready, wb_valid, wb_data, wb_rd, wb_we, fr, br_taken, br_target
  );

  modport master (
    output ex_valid, ex_y, ex_flags, ex_flag_we, ex_rd, ex_rd_we, ex_is_br, ex_cond,
           ex_br_target, wb_ready,
    input  ex_ready, wb_valid, wb_data, wb_rd, wb_we, fr, br_taken, br_target
  );
endinterface

// File: rtl/alu_wb_stage.sv
// Execute->write-back pipeline register, architectural flag register and branch resolution.
// Optional WB_SKID_EN macro: 2-entry skid buffer with a registered ex_ready.
`ifndef DATA_W
  `define DATA_W 16
`endif
`ifndef FR_FLAG_W
  `define FR_FLAG_W 4
`endif
`ifndef N_FLAG
  `define N_FLAG 3
`endif
`ifndef Z_FLAG
  `define Z_FLAG 2
`endif
`ifndef C_FLAG
  `define C_FLAG 1
`endif
`ifndef V_FLAG
  `define V_FLAG 0
`endif

module alu_wb_stage #(
  parameter int REG_ADDR_W = 3,
  parameter int COND_W     = 4
) (
  input logic            clk,
  input logic            rst,
  alu_wb_stage_if.slave  bus
);

  localparam int DW = `DATA_W;
  localparam int FW = `FR_FLAG_W;

  logic                  ex_ready_w;
  logic                  accept;
  logic                  rel;
  logic                  taken;

  logic                  wb_valid_q, wb_valid_d;
  logic [DW-1:0]         wb_data_q, wb_data_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic                  wb_rd_we_q, wb_rd_we_d;
  logic [FW-1:0]         fr_q, fr_d;
  logic                  br_taken_q, br_taken_d;
  logic [DW-1:0]         br_target_q, br_target_d;

`ifdef WB_SKID_EN
  logic                  sk_valid_q, sk_valid_d;
  logic [DW-1:0]         sk_data_q, sk_data_d;
  logic [REG_ADDR_W-1:0] sk_rd_q, sk_rd_d;
  logic                  sk_rd_we_q, sk_rd_we_d;

  // Ready depends only on skid occupancy, so wb_ready never reaches ex_ready combinationally.
  assign ex_ready_w = ~sk_valid_q;
`else
  assign ex_ready_w = ~wb_valid_q | bus.wb_ready;
`endif

  assign accept = bus.ex_valid & ex_ready_w;
  assign rel    = wb_valid_q & bus.wb_ready;

  // C is a borrow flag after SUB, so HI is ~C & ~Z rather than the ARM carry polarity.
  function automatic logic cond_true(input logic [COND_W-1:0] cond, input logic [FW-1:0] f);
    logic n, z, c, v;
    n = f[`N_FLAG];
    z = f[`Z_FLAG];
    c = f[`C_FLAG];
    v = f[`V_FLAG];
    case (int'(cond))
      0:       cond_true = 1'b1;
      1:       cond_true = z;
      2:       cond_true = ~z;
      3:       cond_true = c;
      4:       cond_true = ~c;
      5:       cond_true = n;
      6:       cond_true = ~n;
      7:       cond_true = v;
      8:       cond_true = ~v;
      9:       cond_true = (n == v);
      10:      cond_true = (n != v);
      11:      cond_true = ~z & (n == v);
      12:      cond_true = z | (n != v);
      13:      cond_true = ~c & ~z;
      14:      cond_true = c | z;
      default: cond_true = 1'b0;
    endcase
  endfunction

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_rd_we_d = wb_rd_we_q;
`ifdef WB_SKID_EN
    sk_valid_d = sk_valid_q;
    sk_data_d  = sk_data_q;
    sk_rd_d    = sk_rd_q;
    sk_rd_we_d = sk_rd_we_q;
    if (sk_valid_q) begin
      // Skid full means ex_ready is low: only draining happens this cycle.
      if (rel) begin
        wb_data_d  = sk_data_q;
        wb_rd_d    = sk_rd_q;
        wb_rd_we_d = sk_rd_we_q;
        sk_valid_d = 1'b0;
      end
    end else if (!wb_valid_q || rel) begin
      wb_valid_d = accept;
      if (accept) begin
        wb_data_d  = bus.ex_y;
        wb_rd_d    = bus.ex_rd;
        wb_rd_we_d = bus.ex_rd_we;
      end
    end else if (accept) begin
      sk_valid_d = 1'b1;
      sk_data_d  = bus.ex_y;
      sk_rd_d    = bus.ex_rd;
      sk_rd_we_d = bus.ex_rd_we;
    end
`else
    if (accept) begin
      wb_valid_d = 1'b1;
      wb_data_d  = bus.ex_y;
      wb_rd_d    = bus.ex_rd;
      wb_rd_we_d = bus.ex_rd_we;
    end else if (rel) begin
      wb_valid_d = 1'b0;
    end
`endif
    // Branch sees the flags as they were before this instruction's own flag update.
    taken       = accept & bus.ex_is_br & cond_true(bus.ex_cond, fr_q);
    br_taken_d  = taken;
    br_target_d = taken ? bus.ex_br_target : br_target_q;
    fr_d        = (accept & bus.ex_flag_we) ? bus.ex_flags : fr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_rd_we_q  <= 1'b0;
      fr_q        <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
`ifdef WB_SKID_EN
      sk_valid_q  <= 1'b0;
      sk_data_q   <= '0;
      sk_rd_q     <= '0;
      sk_rd_we_q  <= 1'b0;
`endif
    end else begin
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      wb_rd_we_q  <= wb_rd_we_d;
      fr_q        <= fr_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
`ifdef WB_SKID_EN
      sk_valid_q  <= sk_valid_d;
      sk_data_q   <= sk_data_d;
      sk_rd_q     <= sk_rd_d;
      sk_rd_we_q  <= sk_rd_we_d;
`endif
    end
  end

  assign bus.ex_ready  = ex_ready_w;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_we     = wb_valid_q & wb_rd_we_q;
  assign bus.fr        = fr_q;
  assign bus.br_taken  = br_taken_q;
  assign bus.br_target = br_target_q;

endmodule
